keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, row synchronization,
// whole-scan classification and press/release debouncing.
module keypad_scan #(
    parameter int COL_DWELL      = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (COL_DWELL > 2) ? $clog2(COL_DWELL) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic [3:0]    rowMeta;
    logic [3:0]    rowSync;
    logic [1:0]    colIdx;
    logic [DW-1:0] dwellCnt;
    logic [1:0]    scanLow;
    logic [3:0]    scanCode;
    logic [CW-1:0] pressCnt;
    logic [CW-1:0] releaseCnt;
    logic [3:0]    candidate;

    logic          sampleNow;
    logic          scanDone;
    logic [3:0]    lowBits;
    logic [2:0]    colLow;
    logic [1:0]    rowIdx;
    logic [3:0]    colCode;
    logic [2:0]    totalLow;
    logic [3:0]    newCode;
    logic [CW-1:0] pressNext;
    logic [CW-1:0] releaseNext;

    function automatic logic [3:0] keyMap(input logic [1:0] c,
                                          input logic [1:0] r);
        logic [3:0] k;
        k = 4'h0;
        case ({c, r})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h4;
            4'b00_10: k = 4'h7;
            4'b00_11: k = 4'h0;
            4'b01_00: k = 4'h2;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h8;
            4'b01_11: k = 4'hF;
            4'b10_00: k = 4'h3;
            4'b10_01: k = 4'h6;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hE;
            4'b11_00: k = 4'hA;
            4'b11_01: k = 4'hB;
            4'b11_10: k = 4'hC;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    assign col       = ~(4'b0001 << colIdx);
    assign sampleNow = (dwellCnt == DWELL_LAST);
    assign scanDone  = sampleNow && (colIdx == 2'd3);
    assign lowBits   = ~rowSync;
    assign colLow    = {2'b0, lowBits[0]} + {2'b0, lowBits[1]}
                     + {2'b0, lowBits[2]} + {2'b0, lowBits[3]};
    assign totalLow  = {1'b0, scanLow} + colLow;

    always_comb begin
        rowIdx = 2'd0;
        unique case (lowBits)
            4'b0010: rowIdx = 2'd1;
            4'b0100: rowIdx = 2'd2;
            4'b1000: rowIdx = 2'd3;
            default: rowIdx = 2'd0;
        endcase
    end

    assign colCode     = keyMap(colIdx, rowIdx);
    assign newCode     = (colLow == 3'd1) ? colCode : scanCode;
    assign pressNext   = (pressCnt == CNT_MAX) ? pressCnt : pressCnt + 1'b1;
    assign releaseNext = (releaseCnt == CNT_MAX) ? releaseCnt
                                                 : releaseCnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rowMeta    <= 4'hF;
            rowSync    <= 4'hF;
            colIdx     <= 2'd0;
            dwellCnt   <= '0;
            scanLow    <= 2'd0;
            scanCode   <= 4'h0;
            pressCnt   <= '0;
            releaseCnt <= '0;
            candidate  <= 4'h0;
            key_code   <= 4'h0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            rowMeta   <= row;
            rowSync   <= rowMeta;
            key_valid <= 1'b0;

            if (!key_held && pressCnt == CNT_MAX) begin
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                key_code  <= candidate;
            end else if (key_held && releaseCnt == CNT_MAX) begin
                key_held <= 1'b0;
            end

            if (sampleNow) begin
                dwellCnt <= '0;
                colIdx   <= colIdx + 2'd1;
                if (scanDone) begin
                    scanLow  <= 2'd0;
                    scanCode <= 4'h0;
                    if (totalLow == 3'd0) begin
                        releaseCnt <= releaseNext;
                        pressCnt   <= '0;
                    end else if (totalLow == 3'd1) begin
                        if (newCode == candidate) begin
                            pressCnt <= pressNext;
                        end else begin
                            candidate <= newCode;
                            pressCnt  <= CW'(1);
                        end
                        releaseCnt <= '0;
                    end else begin
                        // MULTI: forget progress, keep candidate
                        pressCnt   <= '0;
                        releaseCnt <= '0;
                    end
                end else begin
                    scanLow  <= (totalLow >= 3'd2) ? 2'd2 : totalLow[1:0];
                    scanCode <= newCode;
                end
            end else begin
                dwellCnt <= dwellCnt + 1'b1;
            end
        end
    end

endmodule
